// File: rtl/bram_port_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : bram_port_arbiter_if
//  Purpose  : Requester-side and BRAM-side signal bundle of the BRAM port
//             arbiter. The slave modport is the arbiter's view and the master
//             modport is the view of the environment around it.
//  Revision : 1.0 - initial release
// ============================================================================
interface bram_port_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_BITW = 32,
  parameter int DATA_BITW = 32
) ();

  // Requester side
  logic [NUM_REQ-1:0]             Req_S;
  logic [NUM_REQ-1:0]             Gnt_S;
  logic [NUM_REQ*ADDR_BITW-1:0]   Addr_S;
  logic [NUM_REQ*DATA_BITW/8-1:0] WrEn_S;
  logic [NUM_REQ*DATA_BITW-1:0]   Wr_D;
  logic [DATA_BITW-1:0]           Rd_D;
  logic [NUM_REQ-1:0]             RdValid_S;

  // BRAM side
  logic                           BramClk_C;
  logic                           BramRst_R;
  logic                           BramEn_S;
  logic [ADDR_BITW-1:0]           BramAddr_S;
  logic [DATA_BITW/8-1:0]         BramWrEn_S;
  logic [DATA_BITW-1:0]           BramWr_D;
  logic [DATA_BITW-1:0]           BramRd_D;

  modport slave (
    input  Req_S, Addr_S, WrEn_S, Wr_D, BramRd_D,
    output Gnt_S, Rd_D, RdValid_S,
    output BramClk_C, BramRst_R, BramEn_S, BramAddr_S, BramWrEn_S, BramWr_D
  );

  modport master (
    output Req_S, Addr_S, WrEn_S, Wr_D, BramRd_D,
    input  Gnt_S, Rd_D, RdValid_S,
    input  BramClk_C, BramRst_R, BramEn_S, BramAddr_S, BramWrEn_S, BramWr_D
  );

endinterface
`default_nettype wire

// File: rtl/bram_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : bram_port_arbiter
//  Purpose  : Round-robin sharing of one BRAM port among NUM_REQ single-beat
//             requesters. Grants are combinational in the request cycle; read
//             responses are routed back to their issuer through a tag pipeline
//             matching the BRAM read latency.
//  Revision : 1.0 - initial release
// ============================================================================
module bram_port_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_BITW  = 32,
  parameter int DATA_BITW  = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic               Clk_C,
  input  logic               Rst_R,
  bram_port_arbiter_if.slave bus
);

  localparam int BE_BITW  = DATA_BITW / 8;
  localparam int IDX_BITW = $clog2(NUM_REQ);
  localparam int LAST     = RD_LATENCY - 1;

  logic [IDX_BITW-1:0] Ptr_q;
  logic [IDX_BITW-1:0] Ptr_d;
  logic                win_vld;
  logic [IDX_BITW-1:0] win_idx;
  int                  cand_idx;
  logic [IDX_BITW-1:0] cand_sel;
  logic [BE_BITW-1:0]  sel_wren;

  // Read-tag pipeline: one {valid, requester index} entry per BRAM latency cycle
  logic [RD_LATENCY-1:0] vld_q;
  logic [IDX_BITW-1:0]   idx_q [RD_LATENCY];

  // The BRAM shares clock and reset with the arbiter
  assign bus.BramClk_C = Clk_C;
  assign bus.BramRst_R = Rst_R;

  // Round-robin search starting at the pointer; nothing wins while in reset
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = '0;
    cand_idx = 0;
    cand_sel = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_idx = (int'(Ptr_q) + k) % NUM_REQ;
      cand_sel = cand_idx[IDX_BITW-1:0];
      if (!win_vld && bus.Req_S[cand_sel] && !Rst_R) begin
        win_vld = 1'b1;
        win_idx = cand_sel;
      end
    end
  end

  // Grant and mux the winner's access onto the BRAM port; all zero when idle
  always_comb begin
    bus.Gnt_S      = '0;
    bus.BramEn_S   = 1'b0;
    bus.BramAddr_S = '0;
    bus.BramWr_D   = '0;
    sel_wren       = '0;
    if (win_vld) begin
      bus.Gnt_S[win_idx] = 1'b1;
      bus.BramEn_S       = 1'b1;
      bus.BramAddr_S     = bus.Addr_S[win_idx*ADDR_BITW +: ADDR_BITW];
      bus.BramWr_D       = bus.Wr_D[win_idx*DATA_BITW +: DATA_BITW];
      sel_wren           = bus.WrEn_S[win_idx*BE_BITW +: BE_BITW];
    end
  end

  assign bus.BramWrEn_S = sel_wren;

  // Pointer moves just past the requester that transferred, wrapping to 0
  always_comb begin
    Ptr_d = Ptr_q;
    if (win_vld) begin
      Ptr_d = (win_idx == IDX_BITW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  // Pointer register and read-tag shift pipeline (never stalls)
  always_ff @(posedge Clk_C) begin
    if (Rst_R) begin
      Ptr_q <= '0;
      vld_q <= '0;
      for (int s = 0; s < RD_LATENCY; s++) begin
        idx_q[s] <= '0;
      end
    end else begin
      Ptr_q    <= Ptr_d;
      vld_q[0] <= win_vld && (sel_wren == '0);
      idx_q[0] <= win_idx;
      for (int s = 1; s < RD_LATENCY; s++) begin
        vld_q[s] <= vld_q[s-1];
        idx_q[s] <= idx_q[s-1];
      end
    end
  end

  // Return the read to its issuer; forced quiet while reset is held
  always_comb begin
    bus.RdValid_S = '0;
    if (vld_q[LAST] && !Rst_R) begin
      bus.RdValid_S[idx_q[LAST]] = 1'b1;
    end
  end

  assign bus.Rd_D = bus.BramRd_D;

endmodule
`default_nettype wire
